// File: rtl/rr_encoder_40b_6b_pkg.sv
// Shared slot-count and index-width definitions for the 40-slot round-robin encoder.
// No logic of its own; the helper below is purely combinational.
// No flow control here; handshake behaviour lives in the top level.
package rr_encoder_40b_6b_pkg;

    localparam int NUM_WF_SLOTS = 40;
    localparam int WF_IDX_W     = 6;

    typedef logic [NUM_WF_SLOTS-1:0] slot_vec_t;
    typedef logic [WF_IDX_W-1:0]     slot_idx_t;

    // Next slot in ring order, 39 wraps back to 0.
    function automatic slot_idx_t slot_inc(input slot_idx_t i);
        return (i == slot_idx_t'(NUM_WF_SLOTS - 1)) ? '0 : i + slot_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_encoder_40b_6b_ff1.sv
// Find-first-set over 40 request bits, starting at base and wrapping 39 -> 0.
// Purely combinational, zero latency.
// No backpressure; caller decides when the result is consumed.
module ff1_rotate_40b
    import rr_encoder_40b_6b_pkg::*;
(
    input  slot_vec_t req,
    input  slot_idx_t base,
    output logic      hit,
    output slot_idx_t idx
);

    always_comb begin
        logic [7:0] pos;
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < NUM_WF_SLOTS; k++) begin
            pos = 8'(base) + 8'(k);
            // Two folds keep an out-of-range base (40..63) inside the ring.
            if (pos >= 8'(NUM_WF_SLOTS)) pos = pos - 8'(NUM_WF_SLOTS);
            if (pos >= 8'(NUM_WF_SLOTS)) pos = pos - 8'(NUM_WF_SLOTS);
            if (!hit && req[pos[5:0]]) begin
                hit = 1'b1;
                idx = pos[5:0];
            end
        end
    end

endmodule

// File: rtl/rr_encoder_40b_6b.sv
// Round-robin encoder: 40-bit request vector -> registered 6-bit slot index plus one-hot grant.
// Latency: 1 cycle from req to out_valid/out_idx; outputs are pure register outputs.
// Backpressure: a live selection is held (sticky) until ack; en=0 flushes it.
module rr_encoder_40b_6b
    import rr_encoder_40b_6b_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_WF_SLOTS-1:0] req,
    input  logic                    ack,
    output logic                    out_valid,
    output logic [WF_IDX_W-1:0]     out_idx,
    output logic [NUM_WF_SLOTS-1:0] out_onehot
);

    slot_idx_t ptr;
    slot_idx_t ptr_nxt;
    logic      ack_live;
    logic      load;
    logic      hit;
    slot_idx_t hit_idx;

    // Ack only counts against a live selection; the search sees the advanced ptr
    // so the just-acked slot drops to lowest priority in the same cycle.
    assign ack_live = ack & out_valid;
    assign ptr_nxt  = ack_live ? slot_inc(out_idx) : ptr;
    assign load     = en & (~out_valid | ack);

    ff1_rotate_40b u_ff1 (
        .req  (req),
        .base (ptr_nxt),
        .hit  (hit),
        .idx  (hit_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            ptr <= ptr_nxt;
            if (!en) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= hit;
                if (hit) out_idx <= hit_idx;
            end
        end
    end

    assign out_onehot = out_valid ? (slot_vec_t'(1) << out_idx) : '0;

endmodule

// File: tb/tb_rr_encoder_40b_6b.sv
module tb_rr_encoder_40b_6b;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [39:0] req;
    logic        ack;
    logic        out_valid;
    logic [5:0]  out_idx;
    logic [39:0] out_onehot;

    int tests_run;
    int tests_failed;

    // Behavioural model: slot numbers as plain ints, ring arithmetic with %.
    int          m_ptr;
    int          m_valid;
    int          m_idx;
    logic [46:0] exp_vec;
    logic [46:0] got_vec;

    rr_encoder_40b_6b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_idx   = 0;
    endfunction

    function automatic void model_step(input logic e, input logic [39:0] r, input logic a);
        int np;
        int found;
        np = (a && m_valid != 0) ? (m_idx + 1) % 40 : m_ptr;
        if (!e) begin
            m_valid = 0;
        end else if (m_valid == 0 || a) begin
            found = -1;
            for (int k = 0; k < 40; k++) begin
                if (found < 0 && r[(np + k) % 40]) found = (np + k) % 40;
            end
            if (found >= 0) begin
                m_valid = 1;
                m_idx   = found;
            end else begin
                m_valid = 0;
            end
        end
        m_ptr = np;
    endfunction

    function automatic logic [46:0] model_outputs();
        logic [39:0] oh;
        oh = '0;
        if (m_valid != 0) oh[m_idx] = 1'b1;
        return {(m_valid != 0), 6'(m_idx), oh};
    endfunction

    // Apply inputs, clock once, update the model, then settle 2 time units past the edge.
    task automatic tick(input logic e, input logic [39:0] r, input logic a);
        en  = e;
        req = r;
        ack = a;
        @(posedge clk);
        model_step(e, r, a);
        #2;
        exp_vec = model_outputs();
        got_vec = {out_valid, out_idx, out_onehot};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        ack   = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({out_valid, out_idx, out_onehot} !== 47'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: got %h expected 0", {out_valid, out_idx, out_onehot});
        end
        tick(1'b1, 40'h1 << 12, 1'b0);
        tests_run++;
        if (got_vec !== exp_vec || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_grant: got %h expected %h", got_vec, exp_vec);
        end
        // Asynchronous assert away from the clock edge must clear outputs at once.
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({out_valid, out_idx, out_onehot} !== 47'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected 0", {out_valid, out_idx, out_onehot});
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, '0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_release_idle: cycle %0d out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, (i < 4) ? (40'h1 << 5) : 40'h0, 1'b0);
            tests_run++;
            if (got_vec !== exp_vec || out_idx !== 6'd5 || out_onehot !== (40'h1 << 5)) begin
                tests_failed++;
                $display("FAIL single_hold: cycle %0d got %h expected %h", i, got_vec, exp_vec);
            end
        end
    endtask

    task automatic test_round_robin();
        int order [8];
        order = '{0, 3, 39, 0, 3, 39, 0, 3};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, (40'h1 << 0) | (40'h1 << 3) | (40'h1 << 39), 1'b1);
            tests_run++;
            if (got_vec !== exp_vec || out_valid !== 1'b1 || int'(out_idx) != order[i]) begin
                tests_failed++;
                $display("FAIL round_robin: step %0d got idx %0d valid %b expected idx %0d", i, out_idx, out_valid, order[i]);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        tick(1'b1, 40'h1 << 38, 1'b0);
        tick(1'b1, (40'h1 << 2) | (40'h1 << 39), 1'b1);
        tests_run++;
        if (got_vec !== exp_vec || out_idx !== 6'd39) begin
            tests_failed++;
            $display("FAIL wrap_39: got idx %0d expected 39", out_idx);
        end
        tick(1'b1, (40'h1 << 2) | (40'h1 << 39), 1'b1);
        tests_run++;
        if (got_vec !== exp_vec || out_idx !== 6'd2) begin
            tests_failed++;
            $display("FAIL wrap_to_2: got idx %0d expected 2", out_idx);
        end
    endtask

    task automatic test_lone_repeat();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 40'h1 << 17, 1'b1);
            tests_run++;
            if (got_vec !== exp_vec || out_valid !== 1'b1 || out_idx !== 6'd17) begin
                tests_failed++;
                $display("FAIL lone_repeat: cycle %0d got valid %b idx %0d expected 1/17", i, out_valid, out_idx);
            end
        end
    endtask

    task automatic test_enable_ack();
        logic [39:0] r;
        r = (40'h1 << 3) | (40'h1 << 7) | (40'h1 << 9);
        // Flush with ack: ptr advances past 7, so the next search lands on 9.
        apply_reset();
        tick(1'b1, 40'h1 << 7, 1'b0);
        tick(1'b0, r, 1'b1);
        tests_run++;
        if (got_vec !== exp_vec || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_flush: got valid %b expected 0", out_valid);
        end
        tick(1'b1, r, 1'b0);
        tests_run++;
        if (got_vec !== exp_vec || out_idx !== 6'd9) begin
            tests_failed++;
            $display("FAIL en_ack_ptr: got idx %0d expected 9", out_idx);
        end
        // Flush without ack, then an idle ack must not move ptr off 0.
        apply_reset();
        tick(1'b1, 40'h1 << 7, 1'b0);
        tick(1'b0, r, 1'b0);
        tick(1'b0, r, 1'b1);
        tick(1'b1, r, 1'b1);
        tests_run++;
        if (got_vec !== exp_vec || out_valid !== 1'b1 || out_idx !== 6'd3) begin
            tests_failed++;
            $display("FAIL idle_ack: got valid %b idx %0d expected 1/3", out_valid, out_idx);
        end
    endtask

    task automatic test_random();
        logic [63:0] w1;
        logic [63:0] w2;
        logic [39:0] r;
        logic        e;
        logic        a;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            w1 = {$urandom(), $urandom()};
            w2 = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = 40'h1 << $urandom_range(0, 39);
                2: r = w1[39:0];
                default: r = w1[39:0] & w2[39:0] & w1[63:24];
            endcase
            e = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 2) != 0);
            tick(e, r, a);
            tests_run++;
            if (got_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL random: cycle %0d got %h expected %h", i, got_vec, exp_vec);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        ack   = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_lone_repeat();
        test_enable_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_encoder_40b_6b.md
# rr_encoder_40b_6b

Round-robin priority encoder for the 40 wavefront slots of a compute unit. It compresses a 40-bit per-slot request vector into one registered 6-bit slot index plus a matching one-hot grant. It holds that selection under a valid/ack handshake until the consumer (issue or fetch arbitration) accepts it. It is the inverse of the 6-to-40 slot decoders used elsewhere in the core.

## Interface
- No parameters; slot count fixed at 40, index width fixed at 6.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  selection enable; low blocks new selections and flushes a held one.
- req  in  40  per-slot request; bit i set means slot i is eligible.
- ack  in  1  consumer accepts the current selection; meaningful only while out_valid=1.
- out_valid  out  1  out_idx/out_onehot hold a live selection.
- out_idx  out  6  selected slot, 0..39; values 40..63 are never produced.
- out_onehot  out  40  one-hot of out_idx when out_valid=1, else all zero.

## Operation
- State: ptr (6b, 0..39, highest-priority slot for the next search), out_valid, out_idx.
- Search: first set bit of req at or after ptr, ascending, wrapping 39→0; at most 40 positions scanned.
- Load condition: en=1 and (out_valid=0 or ack=1).
  - Load and a hit: out_valid←1, out_idx←hit.
  - Load and no hit: out_valid←0.
- Hold: out_valid=1, ack=0, en=1 → out_idx stable, even if req[out_idx] drops (sticky grant).
- Pointer: on ack with out_valid=1, ptr←(out_idx+1) mod 40 (39 wraps to 0). Otherwise ptr is unchanged.
- Same-cycle ack and search: the search uses the updated ptr, so the just-acked slot has lowest priority but is reselected if it is the only requester.
- en=0: out_valid←0 next edge. An ack in that cycle with out_valid=1 still advances ptr.
- ack while out_valid=0: ignored; ptr unchanged.
- req=0 with load condition true: out_valid←0, ptr unchanged.
- out_onehot: derived from registered out_idx and out_valid, gated to zero when out_valid=0.

## Timing
- Reset values (async assert): ptr=0, out_valid=0, out_idx=0, out_onehot=0. Deassertion is synchronous to clk; the first selection appears one edge after the first edge with en=1 and req≠0.
- Latency: req→out_valid/out_idx is 1 cycle (registered outputs; no combinational path from req/ack to outputs).
- Throughput: one grant per cycle with ack held high and multiple requesters.
- Reset mid-selection: out_valid drops immediately (async) and ptr returns to 0; no pending grant survives.

## Structure
- Shared definitions header: NUM_WF_SLOTS=40, WF_IDX_W=6.
- One natural sub-module: ff1_rotate_40b, a combinational find-first-set starting at a 6-bit base with wrap. It returns a hit flag and the index and contains no state.
- Top level holds ptr, the output registers, and the one-hot expansion.

## Test plan
- Reset: assert rst_n=0 mid-run with out_valid=1 → outputs go to zero immediately; after release with req=0, out_valid stays 0.
- Single requester: req=bit 5, en=1, ack=0 → next cycle out_valid=1, out_idx=5, out_onehot=1<<5. It holds 5 for 10 cycles, including after req drops to 0.
- Round-robin: req={0,3,39}, ack=1 every cycle → grants 0,3,39,0,3,…; ptr values after each ack are 1,4,0,1,….
- Wrap: ptr=39 (after acking 38), req={2,39} → grant 39, then ack → grant 2.
- Lone repeat: req=bit 17 constant, ack=1 every cycle → out_idx=17 every cycle with out_valid continuously 1.
- Enable and idle ack: en=0 while out_valid=1 and ack=1 on idx 7 → out_valid=0 next cycle and ptr=8. An ack with out_valid=0 leaves ptr unchanged, checked by the next grant order.
